// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds operand width, M-extension funct3 codes, FSM states and signedness helpers.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // MUL is treated as signed x signed: the low product word is the same either way.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: radix-2 shift-add or restoring shift-subtract.
// Purely combinational; no backpressure.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         is_div,
    input  logic [W:0]   hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] opnd,
    output logic [W:0]   hi_nxt,
    output logic [W-1:0] lo_nxt
);

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W+1:0] diff;

    always_comb begin
        sum     = hi + {1'b0, opnd & {W{lo[0]}}};
        shifted = {hi[W-1:0], lo[W-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (is_div) begin
            // Borrow out of the subtraction means the divisor did not fit: restore.
            if (!diff[W+1]) begin
                hi_nxt = diff[W:0];
                lo_nxt = {lo[W-2:0], 1'b1};
            end else begin
                hi_nxt = shifted;
                lo_nxt = {lo[W-2:0], 1'b0};
            end
        end else begin
            // {hi, lo} holds partial product above the not-yet-consumed multiplier bits.
            hi_nxt = {1'b0, sum[W:1]};
            lo_nxt = {sum[0], lo[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed 34-cycle iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Accepts only while in_ready (IDLE); requests in other states are dropped, flush aborts.
module muldiv_unit #(
    parameter int XLEN = muldiv_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            in_ready,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(ITER);

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   result_q;
    logic              rdy_q;
    logic              busy_q;
    logic              done_q;

    logic              in_neg_a;
    logic              in_neg_b;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN:0]     hi_nxt;
    logic [XLEN-1:0]   lo_nxt;

    always_comb begin
        in_neg_a = op_signed_a(in_op) & in_rs1[XLEN-1];
        in_neg_b = op_signed_b(in_op) & in_rs2[XLEN-1];
        a_abs    = in_neg_a ? (~in_rs1 + 1'b1) : in_rs1;
        b_abs    = in_neg_b ? (~in_rs2 + 1'b1) : in_rs2;
    end

    muldiv_step #(.W(XLEN)) u_step (
        .is_div (op_q[2]),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;
    logic              neg_q;
    logic              div_zero;

    // Signed overflow (MIN / -1) falls out naturally: |MIN|/1 negates back to MIN, remainder 0.
    always_comb begin
        prod     = {hi[XLEN-1:0], lo};
        neg_q    = neg_a ^ neg_b;
        prod_s   = neg_q ? (~prod + 1'b1) : prod;
        quo_s    = neg_q ? (~lo + 1'b1) : lo;
        rem_s    = neg_a ? (~hi[XLEN-1:0] + 1'b1) : hi[XLEN-1:0];
        div_zero = (opnd == '0);
        fix_res  = '0;
        case (op_q)
            OP_MUL:                       fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = div_zero ? '1 : quo_s;
            OP_REM, OP_REMU:              fix_res = div_zero ? src_a : rem_s;
            default:                      fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            src_a    <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush && (state != ST_IDLE)) begin
            state  <= ST_IDLE;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && !flush) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        op_q   <= in_op;
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        src_a  <= in_rs1;
                        hi     <= '0;
                        // Divide shifts the dividend out of lo; multiply consumes the multiplier there.
                        lo     <= in_op[2] ? a_abs : b_abs;
                        opnd   <= in_op[2] ? b_abs : a_abs;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = rdy_q;
    assign busy         = busy_q;
    assign result_valid = done_q & ~flush;
    assign result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: results, fixed latency, flush, reset and ignored requests.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        flush;
    logic        in_ready;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res = 32'h0;

    muldiv_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .flush        (flush),
        .in_ready     (in_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (result_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit poke);
        int          lat = 0;
        bit          got = 0;
        int          w   = 0;
        logic [31:0] e;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(exp);
        chk({tag, "_rdy_low"}, in_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        for (int c = 2; c <= 60 && !got; c++) begin
            if (poke && c == 5) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_op    = 3'b111;
                in_rs1   = 32'd9;
                in_rs2   = 32'd4;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (result_valid) begin
                got = 1;
                lat = c;
            end
        end
        chk({tag, "_latency"}, lat, 34);
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_result"}, result, e);
            last_res = e;
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, result_valid, 1'b0);
        chk({tag, "_rdy_back"}, in_ready, 1'b1);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_op    = 3'b000;
        in_rs1   = 32'h0;
        in_rs2   = 32'h0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
        run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0);
        run_op("div_by0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
        run_op("remu_by0",     3'b111, 32'd5,        32'd0,        32'd5,        1'b0);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0);

        // Flush a MUL 3x4 in its tenth cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_rs1   = 32'd3;
        in_rs2   = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_rdy", in_ready, 1'b1);
        chk("flush_busy", busy, 1'b0);
        chk("flush_result_kept", result, last_res);
        expect_quiet("flush_no_valid", 40);
        run_op("mul_5_6", 3'b000, 32'd5, 32'd6, 32'd30, 1'b0);

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'b100;
        in_rs1   = 32'd1000;
        in_rs2   = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", result_valid, 1'b0);
        chk("arst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        expect_quiet("arst_no_valid", 40);

        // Request together with flush in IDLE is dropped.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 3'b000;
        in_rs1   = 32'd2;
        in_rs2   = 32'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_rdy", in_ready, 1'b1);
        chk("idle_flush_busy", busy, 1'b0);
        expect_quiet("idle_flush_no_valid", 40);

        // A request while busy must be neither executed nor queued.
        run_op("divu_poke", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
        expect_quiet("poke_not_queued", 40);
        chk("poke_result_held", result, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
